reverb_predelay_mc: RTL and testbench

- Parametrised multi-channel predelay line for the reverb audio path; sits between the audio controller Avalon-ST source and the reverb core sink.
- Generalises the fixed stereo, 24-bit, 10-bit-delay predelay path to CHANNELS lanes, DATA_W samples and 2^ADDR_W-deep circular buffers.
- Delay is set at runtime from the HPS PIO (value plus update strobe); delay_active reports the applied delay for HEX display.

---
 rtl/reverb_predelay_mc.sv | 159 +++++++++++++++
 tb/tb_reverb_predelay_mc.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reverb_predelay_mc.sv
`default_nettype none
// ============================================================================
// Module   : reverb_predelay_mc
// Brief    : Multi-channel Avalon-ST predelay line built on a circular frame buffer.
//            Optional macro PREDELAY_RAMP_EN makes delay_active slew by +/-1 per frame.
// Revision : 1.0  initial release
// ============================================================================
module reverb_predelay_mc #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 10,
    parameter int DELAY_W  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS*DATA_W-1:0] sink_data,
    input  logic                       sink_valid,
    output logic                       sink_ready,
    output logic [CHANNELS*DATA_W-1:0] source_data,
    output logic                       source_valid,
    input  logic                       source_ready,
    input  logic [DELAY_W-1:0]         delay_value,
    input  logic                       delay_update,
    output logic [ADDR_W-1:0]          delay_active
);
    localparam int                FRAME_W  = CHANNELS * DATA_W;
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]        S_IDLE   = 2'd0;
    localparam logic [1:0]        S_READ   = 2'd1;
    localparam logic [1:0]        S_HOLD   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    fill_q, fill_d;
    logic [ADDR_W-1:0]  delay_active_q, delay_active_d;
    logic               zero_q, zero_d;
    logic               byp_q, byp_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [FRAME_W-1:0] out_q, out_d;
    logic [FRAME_W-1:0] rd_data_q;
    logic [FRAME_W-1:0] mem [DEPTH];

    logic               w_accept;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ADDR_W-1:0]  w_delay_clamped;

    generate
        if (DELAY_W > ADDR_W) begin : g_delay_sat
            assign w_delay_clamped = (|delay_value[DELAY_W-1:ADDR_W]) ? {ADDR_W{1'b1}}
                                                                      : delay_value[ADDR_W-1:0];
        end else begin : g_delay_ext
            assign w_delay_clamped = ADDR_W'(delay_value);
        end
    endgenerate

    assign w_accept  = sink_valid && sink_ready;
    assign w_rd_addr = wr_ptr_q - delay_active_q;

`ifdef PREDELAY_RAMP_EN
    logic [ADDR_W-1:0] target_q, target_d;

    // Slew happens after the accepted frame has used the current delay for its read address.
    always_comb begin
        target_d       = delay_update ? w_delay_clamped : target_q;
        delay_active_d = delay_active_q;
        if (w_accept) begin
            if (delay_active_q < target_q) begin
                delay_active_d = delay_active_q + 1'b1;
            end else if (delay_active_q > target_q) begin
                delay_active_d = delay_active_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= '0;
        end else begin
            target_q <= target_d;
        end
    end
`else
    always_comb begin
        delay_active_d = delay_update ? w_delay_clamped : delay_active_q;
    end
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        zero_d   = zero_q;
        byp_d    = byp_q;
        frame_d  = frame_q;
        out_d    = out_q;
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            zero_d  = ({1'b0, delay_active_q} > fill_q);
            byp_d   = (delay_active_q == '0);
            frame_d = sink_data;
        end
        // Zero delay reads the slot being written this cycle, so the held input frame is used.
        if (state_q == S_READ) begin
            out_d = zero_q ? '0 : (byp_q ? frame_q : rd_data_q);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem[wr_ptr_q] <= sink_data;
            rd_data_q     <= mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            fill_q         <= '0;
            delay_active_q <= '0;
            zero_q         <= 1'b0;
            byp_q          <= 1'b0;
            frame_q        <= '0;
            out_q          <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_q         <= fill_d;
            delay_active_q <= delay_active_d;
            zero_q         <= zero_d;
            byp_q          <= byp_d;
            frame_q        <= frame_d;
            out_q          <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sink_valid) state_d = S_READ;
            S_READ:  state_d = S_HOLD;
            S_HOLD:  if (source_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sink_ready   = (state_q == S_IDLE) && !reset;
        source_valid = (state_q == S_HOLD);
    end

    assign source_data  = out_q;
    assign delay_active = delay_active_q;

endmodule
`default_nettype wire

// File: tb/tb_reverb_predelay_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_reverb_predelay_mc
// Brief    : Randomized self-checking bench for reverb_predelay_mc against a frame-history model.
// Revision : 1.0  initial release
// ============================================================================
module tb_reverb_predelay_mc;
    localparam int CH    = 2;
    localparam int DW    = 24;
    localparam int AW    = 10;
    localparam int DLW   = 12;
    localparam int W     = CH * DW;
    localparam int DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   sink_data;
    logic           sink_valid;
    logic           sink_ready;
    logic [W-1:0]   source_data;
    logic           source_valid;
    logic           source_ready;
    logic [DLW-1:0] delay_value;
    logic           delay_update;
    logic [AW-1:0]  delay_active;

    int n_pass = 0;
    int n_chk  = 0;

    logic [W-1:0] hist[$];
    int           m_act;
    int           m_tgt;

    reverb_predelay_mc #(
        .CHANNELS (CH),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DELAY_W  (DLW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .delay_value  (delay_value),
        .delay_update (delay_update),
        .delay_active (delay_active)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic model_reset();
        hist.delete();
        m_act = 0;
        m_tgt = 0;
    endtask

    // Output for frame k is frame k-D once k >= D, otherwise silence.
    task automatic model_frame(input logic [W-1:0] f, output logic [W-1:0] e);
        int k;
        hist.push_back(f);
        k = hist.size() - 1;
        e = (k >= m_act) ? hist[k - m_act] : '0;
`ifdef PREDELAY_RAMP_EN
        if (m_act < m_tgt) m_act++;
        else if (m_act > m_tgt) m_act--;
`endif
    endtask

    task automatic set_delay(input int v);
        int c;
        @(negedge clk);
        delay_value  = DLW'(v);
        delay_update = 1'b1;
        @(negedge clk);
        delay_update = 1'b0;
        c = (v > DEPTH - 1) ? DEPTH - 1 : v;
`ifdef PREDELAY_RAMP_EN
        m_tgt = c;
`else
        m_act = c;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one frame; returns model expectation, observed latency/data and stall stability.
    task automatic do_frame(input logic [W-1:0] f, input int stall, output logic [W-1:0] exp_d,
                            output int lat, output logic [W-1:0] got, output bit stall_ok);
        int guard;
        @(negedge clk);
        source_ready = 1'b0;
        sink_data    = f;
        sink_valid   = 1'b1;
        guard        = 0;
        while (!sink_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        model_frame(f, exp_d);
        @(negedge clk);
        sink_valid = 1'b0;
        sink_data  = '0;
        lat        = 1;
        while (!source_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (guard >= 10) lat = -1;
        got      = source_data;
        stall_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!source_valid || sink_ready || source_data !== got) stall_ok = 1'b0;
        end
        source_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if (sink_ready !== 1'b0) $display("FAIL reset_sink_ready_low: got %0b want 0", sink_ready);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (sink_ready !== 1'b1) $display("FAIL reset_sink_ready_high: got %0b want 1", sink_ready);
        else n_pass++;
        n_chk++;
        if (source_valid !== 1'b0) $display("FAIL reset_source_valid: got %0b want 0", source_valid);
        else n_pass++;
        n_chk++;
        if (source_data !== '0) $display("FAIL reset_source_data: got %h want 0", source_data);
        else n_pass++;
        n_chk++;
        if (delay_active !== '0) $display("FAIL reset_delay_active: got %0d want 0", delay_active);
        else n_pass++;
        model_reset();
    endtask

    task automatic test_delay3();
        logic [W-1:0] f, e, g;
        int lat;
        bit ok;
        set_delay(3);
        n_chk++;
        if (delay_active !== AW'(m_act)) $display("FAIL delay3_active: got %0d want %0d", delay_active, m_act);
        else n_pass++;
        for (int i = 1; i <= 6; i++) begin
            f = {DW'($urandom), DW'(i)};
            do_frame(f, 0, e, lat, g, ok);
            n_chk++;
            if (lat != 2) $display("FAIL delay3_latency[%0d]: got %0d want 2", i, lat);
            else n_pass++;
            n_chk++;
            if (g !== e) $display("FAIL delay3_data[%0d]: got %h want %h", i, g, e);
            else n_pass++;
        end
    endtask

    task automatic test_passthrough();
        logic [W-1:0] f, e, g;
        int lat;
        bit ok;
        set_delay(0);
        f = {24'h123456, 24'hABCDEF};
        do_frame(f, 0, e, lat, g, ok);
        n_chk++;
        if (lat != 2) $display("FAIL pass_latency: got %0d want 2", lat);
        else n_pass++;
        n_chk++;
        if (g !== e) $display("FAIL pass_data: got %h want %h", g, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] f, e, g;
        int lat, stall;
        bit ok;
        set_delay(1);
        for (int i = 0; i < 8; i++) begin
            f     = {DW'($urandom), DW'($urandom)};
            stall = (i == 3) ? 5 : 0;
            do_frame(f, stall, e, lat, g, ok);
            n_chk++;
            if (g !== e || lat != 2) $display("FAIL b2b_frame[%0d]: got %h lat %0d want %h lat 2", i, g, lat, e);
            else n_pass++;
            if (stall > 0) begin
                n_chk++;
                if (ok !== 1'b1) $display("FAIL b2b_stall_stable: got %0b want 1", ok);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] f, e, g;
        int lat;
        bit ok;
        set_delay(2000);
        n_chk++;
        if (delay_active !== AW'(m_act)) $display("FAIL wrap_active: got %0d want %0d", delay_active, m_act);
        else n_pass++;
        for (int k = 0; k < 1100; k++) begin
            f = {DW'($urandom), DW'(k)};
            do_frame(f, 0, e, lat, g, ok);
            n_chk++;
            if (g !== e || lat != 2) $display("FAIL wrap_frame[%0d]: got %h lat %0d want %h lat 2", k, g, lat, e);
            else n_pass++;
        end
        n_chk++;
        if (delay_active !== AW'(DEPTH - 1)) $display("FAIL wrap_active_sat: got %0d want %0d", delay_active, DEPTH - 1);
        else n_pass++;
    endtask

    task automatic test_reset_hold();
        logic [W-1:0] f, e, g;
        int lat;
        bit ok;
        set_delay(2);
        for (int i = 0; i < 3; i++) begin
            f = {DW'($urandom), DW'($urandom)};
            do_frame(f, 0, e, lat, g, ok);
        end
        @(negedge clk);
        source_ready = 1'b0;
        sink_data    = {DW'($urandom), DW'($urandom)};
        sink_valid   = 1'b1;
        @(negedge clk);
        sink_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (source_valid !== 1'b1) $display("FAIL hold_reached: got %0b want 1", source_valid);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (source_valid !== 1'b0) $display("FAIL hold_reset_valid: got %0b want 0", source_valid);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        set_delay(2);
        for (int i = 0; i < 2; i++) begin
            f = {DW'($urandom), DW'($urandom)};
            do_frame(f, 0, e, lat, g, ok);
            n_chk++;
            if (g !== e || lat != 2) $display("FAIL post_reset_frame[%0d]: got %h lat %0d want %h lat 2", i, g, lat, e);
            else n_pass++;
        end
    endtask

    task automatic test_ramp();
        logic [W-1:0] f, e, g;
        int lat;
        bit ok;
        do_reset();
        set_delay(4);
`ifdef PREDELAY_RAMP_EN
        for (int i = 0; i < 4; i++) begin
            f = {DW'($urandom), DW'($urandom)};
            do_frame(f, 0, e, lat, g, ok);
            n_chk++;
            if (delay_active !== AW'(i + 1)) $display("FAIL ramp_step[%0d]: got %0d want %0d", i, delay_active, i + 1);
            else n_pass++;
            n_chk++;
            if (g !== e) $display("FAIL ramp_data[%0d]: got %h want %h", i, g, e);
            else n_pass++;
        end
`else
        n_chk++;
        if (delay_active !== AW'(4)) $display("FAIL step_active: got %0d want 4", delay_active);
        else n_pass++;
        f = {DW'($urandom), DW'($urandom)};
        do_frame(f, 0, e, lat, g, ok);
        n_chk++;
        if (g !== e) $display("FAIL step_data: got %h want %h", g, e);
        else n_pass++;
`endif
    endtask

    initial begin
        reset        = 1'b1;
        sink_data    = '0;
        sink_valid   = 1'b0;
        source_ready = 1'b0;
        delay_value  = '0;
        delay_update = 1'b0;
        model_reset();
        test_reset();
        test_delay3();
        test_passthrough();
        test_back_to_back();
        test_wrap();
        test_reset_hold();
        test_ramp();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
